// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one cacheline-wide physical memory port between the instruction
// cache (I), the data cache (D) and the next-line prefetcher (P). Exactly one
// line transaction is in flight at a time. An I-cache miss that hits the line
// a prefetch is already fetching is answered by that prefetch, and a
// contention counter reports how often someone had to wait.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   i_read, i_address     icache line read request (held until i_resp)
//   i_rdata, i_resp       icache line data / completion pulse
//   d_read, d_write       dcache fill / writeback request (write wins if both)
//   d_address, d_wdata    dcache line address / writeback line
//   d_rdata, d_resp       dcache line data / completion pulse
//   p_read, p_address     prefetch line read request
//   p_rdata, p_resp       prefetched line / completion pulse
//   pmem_read, pmem_write memory command, held until pmem_resp
//   pmem_address          line-aligned memory address
//   pmem_wdata            writeback data (zero unless serving a D write)
//   pmem_rdata, pmem_resp memory read data / completion pulse
//   conflict_count        cycles in which a requester waited on another
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LINE_W       = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    input  logic              p_read,
    input  logic [31:0]       p_address,
    output logic [LINE_W-1:0] p_rdata,
    output logic              p_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [31:0]       conflict_count
);

    localparam int          OFFSET     = $clog2(LINE_W / 8);
    localparam logic [31:0] LINE_MASK  = ~((32'd1 << OFFSET) - 32'd1);
    localparam logic [3:0]  STARVE_CAP = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_D,
        SERVE_I,
        SERVE_P,
        RECOVER
    } state_t;

    state_t            state;
    state_t            state_next;

    // Transaction captured at grant time so the requester inputs need not
    // stay meaningful to us while memory is working.
    logic [31:0]       line_address;
    logic [LINE_W-1:0] line_wdata;
    logic              line_is_write;

    logic [31:0]       grant_address;
    logic [LINE_W-1:0] grant_wdata;
    logic              grant_is_write;

    logic [3:0]        d_streak;
    logic [3:0]        d_streak_next;
    logic              waiting;

    logic              d_req;
    logic              i_line_match;
    logic              merge_hit;

    assign d_req        = d_read | d_write;
    assign i_line_match = ((i_address ^ line_address) & LINE_MASK) == 32'd0;
    assign merge_hit    = (state == SERVE_P) && i_read && i_line_match;

    // Returned line data is only driven toward the requester that is being
    // answered this cycle; everyone else sees zero.
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;
    assign p_rdata = p_resp ? pmem_rdata : '0;

    // Next-state and output decode. In IDLE this picks the winner (D over I
    // over P, except that a starved I jumps ahead of D) and prepares the
    // line to capture. In a SERVE state the memory command comes purely from
    // the registered transaction, and the completion pulse follows pmem_resp
    // combinationally. A P completion also answers a waiting I for the same
    // line, which is what makes the merge free.
    always_comb begin
        state_next     = state;
        grant_address  = 32'd0;
        grant_wdata    = '0;
        grant_is_write = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = 32'd0;
        pmem_wdata     = '0;
        i_resp         = 1'b0;
        d_resp         = 1'b0;
        p_resp         = 1'b0;

        case (state)
            IDLE: begin
                if (i_read && (d_streak == STARVE_CAP)) begin
                    state_next    = SERVE_I;
                    grant_address = i_address & LINE_MASK;
                end else if (d_req) begin
                    state_next     = SERVE_D;
                    grant_address  = d_address & LINE_MASK;
                    grant_is_write = d_write;
                    grant_wdata    = d_write ? d_wdata : '0;
                end else if (i_read) begin
                    state_next    = SERVE_I;
                    grant_address = i_address & LINE_MASK;
                end else if (p_read) begin
                    state_next    = SERVE_P;
                    grant_address = p_address & LINE_MASK;
                end
            end

            SERVE_D: begin
                pmem_read    = ~line_is_write;
                pmem_write   = line_is_write;
                pmem_address = line_address;
                pmem_wdata   = line_wdata;
                if (pmem_resp) begin
                    d_resp     = 1'b1;
                    state_next = RECOVER;
                end
            end

            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = line_address;
                if (pmem_resp) begin
                    i_resp     = 1'b1;
                    state_next = RECOVER;
                end
            end

            SERVE_P: begin
                pmem_read    = 1'b1;
                pmem_address = line_address;
                if (pmem_resp) begin
                    p_resp     = 1'b1;
                    i_resp     = merge_hit;
                    state_next = RECOVER;
                end
            end

            RECOVER: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Starvation bookkeeping and contention detection. The streak grows with
    // every D completion that left an I request waiting, saturating at the
    // limit, and is wiped whenever I gets its line (directly or via a merge)
    // or when D completes with nobody from I waiting. A cycle counts as
    // contended when anyone other than the served requester is asking; an I
    // that will be satisfied by the prefetch in flight is not really waiting.
    always_comb begin
        d_streak_next = d_streak;
        waiting       = 1'b0;

        case (state)
            SERVE_D: begin
                waiting = i_read | p_read;
                if (pmem_resp) begin
                    if (!i_read) begin
                        d_streak_next = 4'd0;
                    end else if (d_streak < STARVE_CAP) begin
                        d_streak_next = d_streak + 4'd1;
                    end
                end
            end
            SERVE_I: begin
                waiting = d_req | p_read;
                if (pmem_resp) begin
                    d_streak_next = 4'd0;
                end
            end
            SERVE_P: begin
                waiting = d_req | (i_read & ~i_line_match);
                if (pmem_resp && merge_hit) begin
                    d_streak_next = 4'd0;
                end
            end
            default: begin
                waiting = 1'b0;
            end
        endcase
    end

    // State, captured transaction and counters. Reset may land in the middle
    // of a transaction; everything simply returns to IDLE because the memory
    // side is reset by the same signal and will not answer the old request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            line_address   <= 32'd0;
            line_wdata     <= '0;
            line_is_write  <= 1'b0;
            d_streak       <= 4'd0;
            conflict_count <= 32'd0;
        end else begin
            state          <= state_next;
            d_streak       <= d_streak_next;
            conflict_count <= conflict_count + {31'd0, waiting};
            if (state == IDLE) begin
                line_address  <= grant_address;
                line_wdata    <= grant_wdata;
                line_is_write <= grant_is_write;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the three requesters and plays the memory. A transaction-level
// model (pending request flags, a starvation streak and a contention tally)
// predicts which requester the arbiter must pick, what the memory command
// must look like, who gets a completion pulse, and the contention count.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LINE_W = 256;
    localparam int STARVE = 4;

    localparam int WHO_NONE = 0;
    localparam int WHO_D    = 1;
    localparam int WHO_I    = 2;
    localparam int WHO_P    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read;
    logic [31:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              p_read;
    logic [31:0]       p_address;
    logic [LINE_W-1:0] p_rdata;
    logic              p_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [31:0]       conflict_count;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          model_streak = 0;
    logic [31:0] model_conflicts = 32'd0;
    int          obs_d_resps  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_W(LINE_W), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .p_read(p_read), .p_address(p_address), .p_rdata(p_rdata), .p_resp(p_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .conflict_count(conflict_count)
    );

    // The dcache never asks for a fill and a writeback at once.
    always @(negedge clk) begin
        assert (!(d_read && d_write)) else $error("[TB] d_read and d_write both high");
    end

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lineOf(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] r;
        for (int w = 0; w < LINE_W / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic applyStimulus(input int who, input logic [31:0] addr, input logic wr);
        case (who)
            WHO_I: begin i_read = 1'b1; i_address = addr; end
            WHO_D: begin d_read = ~wr; d_write = wr; d_address = addr; d_wdata = randLine(); end
            WHO_P: begin p_read = 1'b1; p_address = addr; end
            default: ;
        endcase
    endtask

    // Arbitration rule: D before I before P, unless I has sat through the
    // maximum number of consecutive D services.
    function automatic int pickWinner();
        if (i_read && model_streak == STARVE) return WHO_I;
        if (d_read || d_write) return WHO_D;
        if (i_read) return WHO_I;
        if (p_read) return WHO_P;
        return WHO_NONE;
    endfunction

    task automatic randomArrival(input int serving);
        case ($urandom_range(2))
            0: if (!i_read)
                   applyStimulus(WHO_I, (serving == WHO_P && $urandom_range(1) == 1) ?
                                 (lineOf(p_address) | 32'($urandom_range(31))) : $urandom, 1'b0);
            1: if (!(d_read || d_write)) applyStimulus(WHO_D, $urandom, 1'($urandom_range(1)));
            default: if (!p_read) applyStimulus(WHO_P, $urandom, 1'b0);
        endcase
    endtask

    // Called at a drive point in an IDLE cycle with requests already raised.
    // Plays one memory transaction of the given length and returns at the
    // drive point of the IDLE cycle that follows RECOVER.
    task automatic serveTransaction(input int latency, input int arrive_at,
                                    input logic [31:0] arrive_addr, input bit random_arrivals);
        int                who;
        logic              is_wr;
        logic [31:0]       exp_addr;
        logic [LINE_W-1:0] exp_wdata;
        logic [LINE_W-1:0] rdata;
        bit                merged;
        bit                others;
        bit                last;
        bit                i_at_resp;
        who       = pickWinner();
        is_wr     = (who == WHO_D) && d_write;
        exp_addr  = (who == WHO_D) ? lineOf(d_address) :
                    (who == WHO_I) ? lineOf(i_address) : lineOf(p_address);
        exp_wdata = is_wr ? d_wdata : '0;
        rdata     = '0;
        merged    = 1'b0;
        i_at_resp = 1'b0;

        @(negedge clk);
        checkOutput("idle_no_pmem", {pmem_read, pmem_write}, 2'b00);

        for (int n = 1; n <= latency; n++) begin
            last = (n == latency);
            @(posedge clk); #1;
            if (last) begin
                rdata      = randLine();
                pmem_rdata = rdata;
                pmem_resp  = 1'b1;
            end else begin
                if (n == arrive_at && !i_read) applyStimulus(WHO_I, arrive_addr, 1'b0);
                if (random_arrivals && $urandom_range(3) == 0) randomArrival(who);
            end
            @(negedge clk);
            merged = (who == WHO_P) && i_read && (lineOf(i_address) == exp_addr);
            others = ((who != WHO_D) && (d_read || d_write)) ||
                     ((who != WHO_P) && p_read) ||
                     ((who != WHO_I) && i_read && !merged);
            if (others) model_conflicts++;
            checkOutput("pmem_read",    pmem_read, !is_wr);
            checkOutput("pmem_write",   pmem_write, is_wr);
            checkOutput("pmem_address", pmem_address, exp_addr);
            checkOutput("pmem_wdata",   pmem_wdata, exp_wdata);
            checkOutput("i_resp", i_resp, last && (who == WHO_I || merged));
            checkOutput("d_resp", d_resp, last && (who == WHO_D));
            checkOutput("p_resp", p_resp, last && (who == WHO_P));
            if (last) begin
                if (d_resp) obs_d_resps++;
                i_at_resp = i_read;
                checkOutput("i_rdata", i_rdata, (who == WHO_I || merged) ? rdata : '0);
                checkOutput("d_rdata", d_rdata, (who == WHO_D) ? rdata : '0);
                checkOutput("p_rdata", p_rdata, (who == WHO_P) ? rdata : '0);
            end
        end

        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = randLine();
        if (who == WHO_D)
            model_streak = i_at_resp ? ((model_streak < STARVE) ? model_streak + 1 : STARVE) : 0;
        if (who == WHO_I || merged) model_streak = 0;
        if (who == WHO_D) begin d_read = 1'b0; d_write = 1'b0; end
        if (who == WHO_I || merged) i_read = 1'b0;
        if (who == WHO_P) p_read = 1'b0;

        @(negedge clk);
        checkOutput("recover_no_pmem", {pmem_read, pmem_write}, 2'b00);
        checkOutput("recover_no_resp", {i_resp, d_resp, p_resp}, 3'b000);
        checkOutput("recover_rdata_zero", i_rdata | d_rdata | p_rdata, '0);
        checkOutput("conflict_count", conflict_count, model_conflicts);
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; p_read = 1'b0; pmem_resp = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_streak    = 0;
        model_conflicts = 32'd0;
    endtask

    initial begin
        int          d_before;
        int          budget;
        logic [31:0] base;
        reset = 1'b1;
        i_read = 1'b0; i_address = 32'd0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'd0; d_wdata = '0;
        p_read = 1'b0; p_address = 32'd0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
        checkOutput("reset_pmem_address", pmem_address, 32'd0);
        checkOutput("reset_pmem_wdata", pmem_wdata, '0);
        checkOutput("reset_resp", {i_resp, d_resp, p_resp}, 3'b000);
        checkOutput("reset_conflicts", conflict_count, 32'd0);
        reset = 1'b0;

        // Lone icache miss with a slow memory.
        applyStimulus(WHO_I, 32'h0000_1234, 1'b0);
        serveTransaction(5, -1, 32'd0, 1'b0);

        // Writeback and icache miss together: D first, I waits every D cycle.
        base = model_conflicts;
        applyStimulus(WHO_I, 32'h0000_2010, 1'b0);
        applyStimulus(WHO_D, 32'h0000_3F00, 1'b1);
        serveTransaction(3, -1, 32'd0, 1'b0);
        checkOutput("d_then_i_conflicts", conflict_count, base + 32'd3);
        serveTransaction(2, -1, 32'd0, 1'b0);

        // Starvation: D keeps asking while I waits.
        doReset();
        d_before = obs_d_resps;
        budget   = 0;
        applyStimulus(WHO_I, 32'h0000_8000, 1'b0);
        while (i_read && budget < 8) begin
            if (!(d_read || d_write)) applyStimulus(WHO_D, 32'h0000_9000 + 32'(budget * 64), 1'(budget));
            serveTransaction(2, -1, 32'd0, 1'b0);
            budget++;
        end
        checkOutput("starve_d_grants", 32'(obs_d_resps - d_before), 32'd4);
        checkOutput("starve_i_served", i_read, 1'b0);
        applyStimulus(WHO_I, 32'h0000_A000, 1'b0);
        serveTransaction(2, -1, 32'd0, 1'b0);
        serveTransaction(2, -1, 32'd0, 1'b0);

        // Prefetch of line 0x40 absorbs an icache miss to 0x44.
        applyStimulus(WHO_P, 32'h0000_0040, 1'b0);
        serveTransaction(4, 2, 32'h0000_0044, 1'b0);
        @(negedge clk);
        checkOutput("merge_no_reserve", {pmem_read, pmem_write}, 2'b00);
        @(posedge clk); #1;

        // Reset two cycles into a D service.
        applyStimulus(WHO_D, 32'h0000_5000, 1'b0);
        applyStimulus(WHO_I, 32'h0000_6000, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pre_reset_pmem_read", pmem_read, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
        checkOutput("midreset_pmem_address", pmem_address, 32'd0);
        checkOutput("midreset_resp", {i_resp, d_resp, p_resp}, 3'b000);
        checkOutput("midreset_conflicts", conflict_count, 32'd0);
        model_streak    = 0;
        model_conflicts = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        serveTransaction(2, -1, 32'd0, 1'b0);
        serveTransaction(1, -1, 32'd0, 1'b0);

        // Stray memory response while idle.
        pmem_rdata = randLine();
        pmem_resp  = 1'b1;
        @(negedge clk);
        checkOutput("stray_resp", {i_resp, d_resp, p_resp}, 3'b000);
        checkOutput("stray_rdata", i_rdata | d_rdata | p_rdata, '0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        checkOutput("stray_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
        checkOutput("stray_conflicts", conflict_count, model_conflicts);
        @(posedge clk); #1;
        applyStimulus(WHO_P, 32'h0000_7000, 1'b0);
        serveTransaction(1, -1, 32'd0, 1'b0);

        // Random traffic with mid-transaction arrivals.
        for (int iter = 0; iter < 120; iter++) begin
            if (!(i_read || d_read || d_write || p_read)) begin
                if ($urandom_range(1) == 1) applyStimulus(WHO_D, $urandom, 1'($urandom_range(1)));
                if ($urandom_range(1) == 1) applyStimulus(WHO_P, $urandom, 1'b0);
                if ($urandom_range(1) == 1) applyStimulus(WHO_I, $urandom, 1'b0);
                if (!(i_read || d_read || d_write || p_read)) applyStimulus(WHO_P, $urandom, 1'b0);
            end
            serveTransaction(int'($urandom_range(5, 1)), -1, 32'd0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
